// File: rtl/yacht_pkg.sv
// Shared definitions for the yacht scorer: category codes, fixed-score constants,
// FSM state encoding and the face-count histogram types.
package yacht_pkg;

  localparam logic [3:0] CAT_ONES      = 4'd0;
  localparam logic [3:0] CAT_TWOS      = 4'd1;
  localparam logic [3:0] CAT_THREES    = 4'd2;
  localparam logic [3:0] CAT_FOURS     = 4'd3;
  localparam logic [3:0] CAT_FIVES     = 4'd4;
  localparam logic [3:0] CAT_SIXES     = 4'd5;
  localparam logic [3:0] CAT_CHOICE    = 4'd6;
  localparam logic [3:0] CAT_FOURKIND  = 4'd7;
  localparam logic [3:0] CAT_FULLHOUSE = 4'd8;
  localparam logic [3:0] CAT_SSTRAIGHT = 4'd9;
  localparam logic [3:0] CAT_LSTRAIGHT = 4'd10;
  localparam logic [3:0] CAT_YACHT     = 4'd11;

  localparam logic [5:0] SS_SCORE    = 6'd15;
  localparam logic [5:0] LS_SCORE    = 6'd30;
  localparam logic [5:0] YACHT_SCORE = 6'd50;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_COUNT = 3'd2,
    S_EVAL  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Entry [i] holds how many dice show face i+1.
  typedef logic [2:0] cnt_t;
  typedef cnt_t [5:0] hist_t;

endpackage

// File: rtl/yacht_scorer_if.sv
// Request/result bundle between the dice manager (master) and the scorer (slave).
interface yacht_scorer_if #(parameter int SCORE_W = 6);
  // Handshake: start is a request taken only while busy=0; requests while busy are
  // dropped. done is a one-cycle strobe qualifying score/err, which then hold until
  // the next done.
  logic               start;
  logic [3:0]         category;
  logic [2:0]         dice1;
  logic [2:0]         dice2;
  logic [2:0]         dice3;
  logic [2:0]         dice4;
  logic [2:0]         dice5;
  logic               busy;
  logic               done;
  logic [SCORE_W-1:0] score;
  logic               err;

  modport master (
    output start, category, dice1, dice2, dice3, dice4, dice5,
    input  busy, done, score, err
  );

  modport slave (
    input  start, category, dice1, dice2, dice3, dice4, dice5,
    output busy, done, score, err
  );
endinterface

// File: rtl/yacht_scorer_face_histogram.sv
// Six saturating 3-bit face counters fed one die per cycle; faces 0 and 7 are
// flagged as illegal and leave the counters untouched.
module face_histogram
  import yacht_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear_i,
  input  logic       inc_i,
  input  logic [2:0] face_i,
  output hist_t      counts_o,
  output logic       illegal_o
);

  hist_t counts_q;

  assign illegal_o = (face_i == 3'd0) || (face_i == 3'd7);
  assign counts_o  = counts_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counts_q <= '0;
    end else if (clear_i) begin
      counts_q <= '0;
    end else if (inc_i && !illegal_o) begin
      for (int i = 0; i < 6; i++) begin
        if (face_i == 3'(i + 1) && counts_q[i] != 3'd7) begin
          counts_q[i] <= counts_q[i] + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/yacht_scorer.sv
// Multi-cycle Yacht score evaluator: latch dice, histogram them one per cycle,
// then score the requested category in a single evaluation cycle.
module yacht_scorer
  import yacht_pkg::*;
#(
  parameter int SCORE_W = 6
) (
  input  logic           clk,
  input  logic           reset_n,
  yacht_scorer_if.slave  bus,
  output state_t         state_o
);

  state_t             state_q, state_d;
  logic [4:0][2:0]    dice_q;
  logic [3:0]         cat_q;
  logic [2:0]         idx_q;
  logic [4:0]         sum_q;
  logic               err_pend_q;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               err_q, err_d;

  logic  latch, hist_clear, hist_inc, eval_en, done;
  logic  [2:0] face;
  logic  illegal;
  hist_t counts;

  face_histogram u_hist (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear_i   (hist_clear),
    .inc_i     (hist_inc),
    .face_i    (face),
    .counts_o  (counts),
    .illegal_o (illegal)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_LOAD;
      S_LOAD:  state_d = S_COUNT;
      S_COUNT: if (idx_q == 3'd4) state_d = S_EVAL;
      S_EVAL:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    latch      = 1'b0;
    hist_clear = 1'b0;
    hist_inc   = 1'b0;
    eval_en    = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_IDLE:  latch      = bus.start;
      S_LOAD:  hist_clear = 1'b1;
      S_COUNT: hist_inc   = 1'b1;
      S_EVAL:  eval_en    = 1'b1;
      S_DONE:  done       = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    case (idx_q)
      3'd0:    face = dice_q[0];
      3'd1:    face = dice_q[1];
      3'd2:    face = dice_q[2];
      3'd3:    face = dice_q[3];
      3'd4:    face = dice_q[4];
      default: face = 3'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dice_q     <= '0;
      cat_q      <= '0;
      idx_q      <= '0;
      sum_q      <= '0;
      err_pend_q <= 1'b0;
      score_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (latch) begin
        dice_q <= {bus.dice5, bus.dice4, bus.dice3, bus.dice2, bus.dice1};
        cat_q  <= bus.category;
      end
      if (hist_clear) begin
        idx_q      <= '0;
        sum_q      <= '0;
        err_pend_q <= 1'b0;
      end else if (hist_inc) begin
        idx_q <= idx_q + 3'd1;
        if (illegal) err_pend_q <= 1'b1;
        else         sum_q      <= sum_q + {2'b00, face};
      end
      if (eval_en) begin
        score_q <= score_d;
        err_q   <= err_d;
      end
    end
  end

  logic [5:0] present;
  logic       has2, has3, has4, has5;
  logic [2:0] cnt_sel, face_mul;
  logic [5:0] raw, sum6;
  logic       bad;

  // Score evaluation from the finished histogram and running sum.
  always_comb begin
    has2    = 1'b0;
    has3    = 1'b0;
    has4    = 1'b0;
    has5    = 1'b0;
    present = '0;
    cnt_sel = '0;
    for (int i = 0; i < 6; i++) begin
      present[i] = (counts[i] != 3'd0);
      has2 = has2 | (counts[i] == 3'd2);
      has3 = has3 | (counts[i] == 3'd3);
      has4 = has4 | (counts[i] >= 3'd4);
      has5 = has5 | (counts[i] == 3'd5);
      if (cat_q == 4'(i)) cnt_sel = counts[i];
    end
    face_mul = cat_q[2:0] + 3'd1;
    sum6     = {1'b0, sum_q};
    raw      = '0;
    bad      = err_pend_q;
    case (cat_q)
      CAT_ONES, CAT_TWOS, CAT_THREES, CAT_FOURS, CAT_FIVES, CAT_SIXES:
        raw = 6'(face_mul) * 6'(cnt_sel);
      CAT_CHOICE:    raw = sum6;
      CAT_FOURKIND:  raw = has4 ? sum6 : 6'd0;
      CAT_FULLHOUSE: raw = (has3 && has2) ? sum6 : 6'd0;
      CAT_SSTRAIGHT:
        raw = ((&present[3:0]) || (&present[4:1]) || (&present[5:2])) ? SS_SCORE : 6'd0;
      CAT_LSTRAIGHT:
        raw = ((&present[4:0]) || (&present[5:1])) ? LS_SCORE : 6'd0;
      CAT_YACHT:     raw = has5 ? YACHT_SCORE : 6'd0;
      default:       bad = 1'b1;
    endcase
    if (bad) raw = '0;
    score_d = SCORE_W'(raw);
    err_d   = bad;
  end

  assign bus.busy  = (state_q != S_IDLE);
  assign bus.done  = done;
  assign bus.score = score_q;
  assign bus.err   = err_q;
  assign state_o   = state_q;

endmodule

// File: doc/yacht_scorer.md
YACHT_SCORER -- requirements
Module: yacht_scorer

Interface
REQ-001 SHALL have parameter: SCORE_W, default 6, score output width (minimum 6, holds 0..50).
REQ-002 SHALL have port: clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port: reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  request one score evaluation, sampled only in IDLE.
REQ-005 SHALL have port: category  input  4  scoring category per package encoding, latched with start.
REQ-006 SHALL have ports: dice1..dice5  input  3 each  face values 1..6 from the dice manager, latched with start.
REQ-007 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port: done  output  1  single-cycle pulse, result valid.
REQ-009 SHALL have port: score  output  SCORE_W  last computed score, held until the next done.
REQ-010 SHALL have port: err  output  1  last evaluation had an illegal die value or category, updated with score.

Function
REQ-011 SHALL implement FSM IDLE -> LOAD -> COUNT -> EVAL -> DONE -> IDLE.
REQ-012 IDLE with start=1 SHALL latch dice1..5 and category and go to LOAD; start=0 stays IDLE.
REQ-013 LOAD SHALL clear the six face counters and err_pending, one cycle.
REQ-014 COUNT SHALL last exactly 5 cycles, one latched die per cycle (die index 0..4 via 3-bit counter), incrementing counter[face]; a face of 0 or 7 sets err_pending and increments nothing.
REQ-015 EVAL SHALL compute the score from counters and sum, one cycle, registering score and err.
REQ-016 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-017 Latency: done SHALL be high in the 8th cycle after the edge that samples start (1 LOAD + 5 COUNT + 1 EVAL + 1 DONE).
REQ-018 start while busy SHALL be ignored, with no queuing; dice or category changes while busy SHALL NOT affect the result.
REQ-019 Categories 0..5 (Ones..Sixes) SHALL score (category+1) x counter[category+1].
REQ-020 Category 6 (Choice) SHALL score the sum of all five dice.
REQ-021 Category 7 (FourKind) SHALL score the sum of all dice if any counter >= 4, else 0.
REQ-022 Category 8 (FullHouse) SHALL score the sum of all dice if one counter = 3 and another = 2, else 0; five of a kind SHALL score 0.
REQ-023 Category 9 (SmallStraight) SHALL score 15 if faces {1-4}, {2-5} or {3-6} are all present, else 0.
REQ-024 Category 10 (LargeStraight) SHALL score 30 if {1-5} or {2-6} are all present, else 0.
REQ-025 Category 11 (Yacht) SHALL score 50 if any counter = 5, else 0.
REQ-026 Category 12..15, or err_pending, SHALL give score=0 and err=1.
REQ-027 The sum SHALL be accumulated at 5-bit width (max 30) and zero-extended to SCORE_W; counters SHALL be 3-bit (max 5) with no wrap.

Reset
REQ-028 reset_n low SHALL force IDLE, busy=0, done=0, score=0, err=0, counters=0, die index=0, immediately and asynchronously.
REQ-029 Reset mid-operation SHALL abort with no done pulse; the first start after release SHALL be a fresh evaluation.

Structure
REQ-030 Shared package yacht_pkg SHALL hold the category encodings (CAT_ONES=0 .. CAT_YACHT=11), the FSM state enum, and the constants SS_SCORE=15, LS_SCORE=30, YACHT_SCORE=50.
REQ-031 The face counters, their clear and their increment SHALL live in sub-module face_histogram (clear, inc, face[2:0] -> six 3-bit counts, illegal-face flag).

Verification
REQ-032 Dice 3,3,3,5,5 with FullHouse -> done in cycle 8, score=19, err=0; same dice with FourKind -> score=0.
REQ-033 Dice 6,6,6,6,6 with Yacht -> 50; with FullHouse -> 0; with Sixes -> 30; with FourKind -> 30.
REQ-034 Dice 2,3,4,5,1 with LargeStraight -> 30; dice 1,2,3,4,6 with SmallStraight -> 15 and with LargeStraight -> 0.
REQ-035 Dice 1,2,0,4,5 with Choice -> score=0, err=1; any legal dice with category 13 -> score=0, err=1.
REQ-036 Second start pulsed in cycle 3 of an evaluation, with dice changed in cycle 4 -> a single done pulse, score from the first latched dice.
REQ-037 reset_n low during COUNT -> busy=0, score=0 immediately, no done; a new start after release -> correct result 8 cycles later.
